// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST master: FSM states,
// pattern selector codes and the checkerboard byte values.
package mem_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PAT_ADDR     = 2'd0;
    localparam logic [1:0] PAT_INV_ADDR = 2'd1;
    localparam logic [1:0] PAT_CHECKER  = 2'd2;
    localparam logic [1:0] PAT_ONES     = 2'd3;

    localparam logic [7:0] CHECKER_EVEN = 8'h55;
    localparam logic [7:0] CHECKER_ODD  = 8'hAA;

endpackage

// File: rtl/mem_bist_patgen.sv
// Combinational pattern generator: maps (pattern code, address) to the data
// word that belongs at that address. Used for both write data and compare.
module mem_bist_patgen
    import mem_bist_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [1:0]            pattern,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      data
);

    localparam int REPS = (WIDTH + 7) / 8;

    logic [REPS*8-1:0] even_word;
    logic [REPS*8-1:0] odd_word;
    logic [WIDTH-1:0]  addr_word;

    // Checker bytes are replicated up to the data width, then truncated.
    assign even_word = {REPS{CHECKER_EVEN}};
    assign odd_word  = {REPS{CHECKER_ODD}};
    assign addr_word = WIDTH'(addr);

    always_comb begin
        data = '1;
        case (pattern)
            PAT_ADDR:     data = addr_word;
            PAT_INV_ADDR: data = ~addr_word;
            PAT_CHECKER:  data = addr[0] ? odd_word[WIDTH-1:0] : even_word[WIDTH-1:0];
            default:      data = '1;
        endcase
    end

endmodule

// File: rtl/mem_bist_master.sv
// BIST bus master: writes a generated pattern over an address window, reads it
// back and compares, with a handshake timeout guarding every request.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            pattern,
    input  logic                  down,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_rd,
    output logic [WIDTH-1:0]      w_data,
    output logic                  valid,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      r_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  timeout,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t state, state_next;

    logic [1:0]            pat_q;
    logic                  down_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         idx;
    logic [TW-1:0]         wait_cnt;

    logic                  accept;
    logic                  xfer;
    logic                  last;
    logic                  expire;
    logic                  mismatch;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_pat;
    logic [WIDTH-1:0]      req_data;
    logic [WIDTH-1:0]      exp_data;

    // Window addresses wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic dn);
        if (dn)
            return (a == '0) ? ADDR_WIDTH'(DEPTH - 1) : a - ADDR_WIDTH'(1);
        else
            return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    mem_bist_patgen #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_gen_req (
        .pattern (req_pat),
        .addr    (req_addr),
        .data    (req_data)
    );

    mem_bist_patgen #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_gen_cmp (
        .pattern (pat_q),
        .addr    (addr),
        .data    (exp_data)
    );

    always_comb begin
        accept     = (state == IDLE) && start;
        xfer       = valid && ready;
        last       = (idx == count_q - CW'(1));
        expire     = valid && !ready && (wait_cnt == TW'(TIMEOUT - 1));
        mismatch   = (state == READ) && xfer && (r_data != exp_data);
        req_pat    = accept ? pattern : pat_q;
        req_addr   = step_addr(addr, down_q);
        state_next = state;

        // The read pass restarts at base; the start edge uses the raw inputs.
        if (accept)
            req_addr = base;
        else if ((state == WRITE) && last)
            req_addr = base_q;

        case (state)
            IDLE:  if (start) state_next = (count == '0) ? DONE : WRITE;
            WRITE: if (expire) state_next = DONE;
                   else if (xfer && last) state_next = READ;
            READ:  if (expire || (xfer && last)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == WRITE) || (state == READ);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            down_q    <= 1'b0;
            base_q    <= '0;
            count_q   <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
            addr      <= '0;
            wr_rd     <= 1'b0;
            w_data    <= '0;
            valid     <= 1'b0;
            error     <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pat_q     <= pattern;
                down_q    <= down;
                base_q    <= base;
                count_q   <= count;
                idx       <= '0;
                wait_cnt  <= '0;
                error     <= 1'b0;
                timeout   <= 1'b0;
                err_count <= '0;
                err_addr  <= '0;
                if (count != '0) begin
                    valid  <= 1'b1;
                    wr_rd  <= 1'b1;
                    addr   <= req_addr;
                    w_data <= req_data;
                end
            end else if (expire) begin
                valid   <= 1'b0;
                timeout <= 1'b1;
                error   <= 1'b1;
            end else if (xfer) begin
                wait_cnt <= '0;
                if (mismatch) begin
                    error <= 1'b1;
                    if (err_count != '1)
                        err_count <= err_count + CW'(1);
                    if (err_count == '0)
                        err_addr <= addr;
                end
                if (last) begin
                    idx <= '0;
                    if (state == WRITE) begin
                        wr_rd  <= 1'b0;
                        addr   <= req_addr;
                        w_data <= req_data;
                    end else begin
                        valid <= 1'b0;
                    end
                end else begin
                    idx    <= idx + CW'(1);
                    addr   <= req_addr;
                    w_data <= req_data;
                end
            end else if (valid) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
        end
    end

endmodule
